// File: rtl/cmd_grant_arbiter_aged_if.sv
// CMD-bus grant handshake between the RankControllers and the channel arbiter.
// CMDGRANT_STATS_EN adds the per-rank grant and starvation counter outputs.
interface cmd_grant_arbiter_aged_if #(
  parameter int NUMRANK = 4,
  parameter int RW      = 3,
  parameter int WW      = 3
);
  logic [NUMRANK-1:0]    readyRdVector;
  logic [NUMRANK-1:0]    readyWrVector;
  logic [NUMRANK-1:0]    fsmWaitVector;
  logic [NUMRANK*RW-1:0] readReqCnt;
  logic [NUMRANK*WW-1:0] writeReqCnt;
  logic                  grantACK;
  logic                  writeMode;
  logic [NUMRANK-1:0]    CMDGrantVector;
  logic                  rankTransition;
  logic                  starveGrant;
`ifdef CMDGRANT_STATS_EN
  logic [NUMRANK*16-1:0] grantCount;
  logic [15:0]           starveCount;

  modport master (
    output readyRdVector, readyWrVector, fsmWaitVector, readReqCnt, writeReqCnt,
    output grantACK, writeMode,
    input  CMDGrantVector, rankTransition, starveGrant, grantCount, starveCount
  );
  modport slave (
    input  readyRdVector, readyWrVector, fsmWaitVector, readReqCnt, writeReqCnt,
    input  grantACK, writeMode,
    output CMDGrantVector, rankTransition, starveGrant, grantCount, starveCount
  );
`else
  modport master (
    output readyRdVector, readyWrVector, fsmWaitVector, readReqCnt, writeReqCnt,
    output grantACK, writeMode,
    input  CMDGrantVector, rankTransition, starveGrant
  );
  modport slave (
    input  readyRdVector, readyWrVector, fsmWaitVector, readReqCnt, writeReqCnt,
    input  grantACK, writeMode,
    output CMDGrantVector, rankTransition, starveGrant
  );
`endif
endinterface

// File: rtl/cmd_grant_arbiter_aged.sv
// Channel CMD-bus arbiter: age override, then deepest queue, then round-robin; tRTR gap on rank switch.
// Optional CMDGRANT_STATS_EN adds saturating grant/starvation counters.
module cmd_grant_arbiter_aged #(
  parameter int NUMRANK            = 4,
  parameter int READCMDQUEUEDEPTH  = 8,
  parameter int WRITECMDQUEUEDEPTH = 8,
  parameter int AGELIMIT           = 16,
  parameter int TRTR               = 2
) (
  input logic                     clk,
  input logic                     rst,
  cmd_grant_arbiter_aged_if.slave bus
);
  localparam int RW = $clog2(READCMDQUEUEDEPTH);
  localparam int WW = $clog2(WRITECMDQUEUEDEPTH);
  localparam int CW = (RW > WW) ? RW : WW;
  localparam int AW = $clog2(AGELIMIT + 1);
  localparam int PW = $clog2(NUMRANK);
  localparam int GW = (TRTR > 1) ? $clog2(TRTR + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state, state_d;
  logic [NUMRANK-1:0] grant, grant_d;
  logic               rt_q, rt_d, sg_q, sg_d;
  logic [GW-1:0]      gap_cnt, gap_d;
  logic [PW-1:0]      rr_ptr, last_rank;
  logic               last_valid, wm_q;
  logic [AW-1:0]      age [NUMRANK];

  logic [NUMRANK-1:0] avail, starve, deep, next_cmd;
  logic [CW-1:0]      cnt [NUMRANK];
  logic [CW-1:0]      max_cnt;
  logic               any_starve, ack_ok, mode_toggle;
  logic [PW-1:0]      g_idx, g_next, nc_idx, rr_eff;

  function automatic logic [NUMRANK-1:0] pick(input logic [NUMRANK-1:0] m, input logic [PW-1:0] ptr);
    logic [NUMRANK-1:0] r;
    logic               found;
    int unsigned        j;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUMRANK; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUMRANK) j = j - NUMRANK;
      if (!found && m[PW'(j)]) begin
        r[PW'(j)] = 1'b1;
        found     = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] idx_of(input logic [NUMRANK-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUMRANK; i++) begin
      if (oh[i]) r = r | PW'(i);
    end
    return r;
  endfunction

  always_comb begin
    avail = (bus.writeMode ? bus.readyWrVector : bus.readyRdVector) & ~bus.fsmWaitVector;
    for (int unsigned i = 0; i < NUMRANK; i++) begin
      cnt[i] = bus.writeMode ? CW'(bus.writeReqCnt[i*WW +: WW]) : CW'(bus.readReqCnt[i*RW +: RW]);
    end
  end

  always_comb begin
    max_cnt = '0;
    for (int unsigned i = 0; i < NUMRANK; i++) begin
      if (avail[i] && (cnt[i] > max_cnt)) max_cnt = cnt[i];
    end
  end

  always_comb begin
    starve = '0;
    deep   = '0;
    for (int unsigned i = 0; i < NUMRANK; i++) begin
      starve[i] = avail[i] && (age[i] == AW'(AGELIMIT));
      deep[i]   = avail[i] && (cnt[i] == max_cnt);
    end
  end

  // On an ACK cycle arbitration already uses the advanced pointer, so the
  // rank just served loses round-robin ties to its successors.
  always_comb begin
    ack_ok      = bus.grantACK && (|grant);
    mode_toggle = bus.writeMode != wm_q;
    g_idx       = idx_of(grant);
    g_next      = (g_idx == PW'(NUMRANK - 1)) ? '0 : g_idx + PW'(1);
    rr_eff      = ack_ok ? g_next : rr_ptr;
    any_starve  = |starve;
    next_cmd    = any_starve ? pick(starve, rr_eff) : pick(deep, rr_eff);
    nc_idx      = idx_of(next_cmd);
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    gap_d   = gap_cnt;
    rt_d    = 1'b0;
    sg_d    = 1'b0;
    case (state)
      IDLE: begin
        if (|next_cmd) begin
          if (!last_valid || (nc_idx == last_rank) || (TRTR == 0)) begin
            grant_d = next_cmd;
            rt_d    = last_valid && (nc_idx != last_rank);
            sg_d    = any_starve;
            state_d = GRANT;
          end else begin
            gap_d   = GW'(TRTR);
            state_d = GAP;
          end
        end
      end
      GRANT: begin
        if (ack_ok) begin
          if (next_cmd == '0) begin
            grant_d = '0;
            state_d = IDLE;
          end else if ((nc_idx == g_idx) || (TRTR == 0)) begin
            grant_d = next_cmd;
            rt_d    = nc_idx != g_idx;
            sg_d    = any_starve;
          end else begin
            grant_d = '0;
            gap_d   = GW'(TRTR);
            state_d = GAP;
          end
        end else if (((grant & avail) == '0) || mode_toggle) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          if (|next_cmd) begin
            grant_d = next_cmd;
            rt_d    = last_valid && (nc_idx != last_rank);
            sg_d    = any_starve;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      rt_q       <= 1'b0;
      sg_q       <= 1'b0;
      gap_cnt    <= '0;
      rr_ptr     <= '0;
      last_rank  <= '0;
      last_valid <= 1'b0;
      wm_q       <= 1'b0;
      for (int unsigned i = 0; i < NUMRANK; i++) age[i] <= '0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      rt_q    <= rt_d;
      sg_q    <= sg_d;
      gap_cnt <= gap_d;
      wm_q    <= bus.writeMode;
      if (ack_ok) begin
        rr_ptr     <= g_next;
        last_rank  <= g_idx;
        last_valid <= 1'b1;
      end
      for (int unsigned i = 0; i < NUMRANK; i++) begin
        if (!avail[i] || (grant[i] && bus.grantACK)) age[i] <= '0;
        else if (age[i] != AW'(AGELIMIT)) age[i] <= age[i] + AW'(1);
      end
    end
  end

  assign bus.CMDGrantVector = grant;
  assign bus.rankTransition = rt_q;
  assign bus.starveGrant    = sg_q;

`ifdef CMDGRANT_STATS_EN
  logic [15:0] grant_count [NUMRANK];
  logic [15:0] starve_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_count <= '0;
      for (int unsigned i = 0; i < NUMRANK; i++) grant_count[i] <= '0;
    end else begin
      if (sg_q && (starve_count != '1)) starve_count <= starve_count + 16'd1;
      for (int unsigned i = 0; i < NUMRANK; i++) begin
        if (ack_ok && grant[i] && (grant_count[i] != '1)) grant_count[i] <= grant_count[i] + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUMRANK; gi++) begin : g_stats
    assign bus.grantCount[gi*16 +: 16] = grant_count[gi];
  end
  assign bus.starveCount = starve_count;
`endif
endmodule

// File: tb/tb_cmd_grant_arbiter_aged.sv
// Directed bench for cmd_grant_arbiter_aged (NUMRANK=4, AGELIMIT=4, TRTR=2).
module tb_cmd_grant_arbiter_aged;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cmd_grant_arbiter_aged_if #(.NUMRANK(4), .RW(3), .WW(3)) bus ();

  cmd_grant_arbiter_aged #(
    .NUMRANK(4),
    .READCMDQUEUEDEPTH(8),
    .WRITECMDQUEUEDEPTH(8),
    .AGELIMIT(4),
    .TRTR(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [3:0]  wt;
    logic [11:0] rc;
    logic [11:0] wc;
    logic [3:0]  exp_g;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic mode, input logic [3:0] rd, input logic [3:0] wr,
                        input logic [3:0] wt, input logic [11:0] rc, input logic [11:0] wc);
    bus.writeMode     = mode;
    bus.readyRdVector = rd;
    bus.readyWrVector = wr;
    bus.fsmWaitVector = wt;
    bus.readReqCnt    = rc;
    bus.writeReqCnt   = wc;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Asserts reset asynchronously, checks outputs clear at once, applies inputs, releases at a negedge.
  task automatic reset_to(input logic mode, input logic [3:0] rd, input logic [3:0] wr,
                          input logic [3:0] wt, input logic [11:0] rc, input logic [11:0] wc);
    bus.grantACK = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.CMDGrantVector), 32'h0);
    chk("rst_rt", 32'(bus.rankTransition), 32'h0);
    chk("rst_sg", 32'(bus.starveGrant), 32'h0);
    set_in(mode, rd, wr, wt, rc, wc);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 12'h0, 12'h0);
    bus.grantACK = 1'b0;
    // counts packed {r3,r2,r1,r0}
    vecs[0] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, {3'd3, 3'd2, 3'd5, 3'd1}, 12'h0, 4'b0010};
    vecs[1] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, {3'd3, 3'd3, 3'd3, 3'd3}, 12'h0, 4'b0001};
    vecs[2] = '{1'b0, 4'b1100, 4'b0000, 4'b0000, {3'd3, 3'd3, 3'd3, 3'd3}, 12'h0, 4'b0100};
    vecs[3] = '{1'b0, 4'b1111, 4'b0000, 4'b0010, {3'd6, 3'd0, 3'd7, 3'd0}, 12'h0, 4'b1000};
    vecs[4] = '{1'b1, 4'b1111, 4'b0101, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd7}, {3'd0, 3'd4, 3'd0, 3'd2}, 4'b0100};
    vecs[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, {3'd3, 3'd3, 3'd3, 3'd3}, 12'h0, 4'b0000};
    vecs[6] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, {3'd1, 3'd1, 3'd1, 3'd1}, 12'h0, 4'b0000};
    vecs[7] = '{1'b1, 4'b0000, 4'b1010, 4'b0000, 12'h0, {3'd7, 3'd0, 3'd7, 3'd0}, 4'b0010};
    vecs[8] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 12'h0, 12'h0, 4'b0001};
    vecs[9] = '{1'b0, 4'b0110, 4'b1001, 4'b0000, {3'd0, 3'd1, 3'd1, 3'd0}, {3'd7, 3'd7, 3'd7, 3'd7}, 4'b0010};

    #2;
    for (int v = 0; v < 10; v++) begin
      reset_to(vecs[v].mode, vecs[v].rd, vecs[v].wr, vecs[v].wt, vecs[v].rc, vecs[v].wc);
      step();
      chk($sformatf("vec%0d_grant", v), 32'(bus.CMDGrantVector), 32'(vecs[v].exp_g));
      chk($sformatf("vec%0d_sg", v), 32'(bus.starveGrant), 32'h0);
    end

    // Equal depths: r0 first, ACK opens a 2-cycle gap, then r1 with transition pulse
    reset_to(1'b0, 4'b1111, 4'b0000, 4'b0000, {3'd3, 3'd3, 3'd3, 3'd3}, 12'h0);
    step();
    chk("tie_first", 32'(bus.CMDGrantVector), 32'h1);
    bus.grantACK = 1'b1;
    step();
    chk("tie_gap1", 32'(bus.CMDGrantVector), 32'h0);
    bus.grantACK = 1'b0;
    step();
    chk("tie_gap2", 32'(bus.CMDGrantVector), 32'h0);
    step();
    chk("tie_second", 32'(bus.CMDGrantVector), 32'h2);
    chk("tie_rt", 32'(bus.rankTransition), 32'h1);
    chk("tie_sg", 32'(bus.starveGrant), 32'h0);
    step();
    chk("tie_hold", 32'(bus.CMDGrantVector), 32'h2);
    chk("tie_rt_pulse", 32'(bus.rankTransition), 32'h0);

    // Starvation: r0 deep and repeatedly acked, r3 shallow ages out
    reset_to(1'b0, 4'b1001, 4'b0000, 4'b0000, {3'd1, 3'd0, 3'd0, 3'd7}, 12'h0);
    step();
    chk("stv_e1", 32'(bus.CMDGrantVector), 32'h1);
    bus.grantACK = 1'b1;
    step();
    chk("stv_e2", 32'(bus.CMDGrantVector), 32'h1);
    chk("stv_e2_sg", 32'(bus.starveGrant), 32'h0);
    step();
    chk("stv_e3", 32'(bus.CMDGrantVector), 32'h1);
    step();
    chk("stv_e4", 32'(bus.CMDGrantVector), 32'h1);
    step();
    chk("stv_gap1", 32'(bus.CMDGrantVector), 32'h0);
    step();
    chk("stv_gap2", 32'(bus.CMDGrantVector), 32'h0);
    step();
    chk("stv_grant", 32'(bus.CMDGrantVector), 32'h8);
    chk("stv_sg", 32'(bus.starveGrant), 32'h1);
    chk("stv_rt", 32'(bus.rankTransition), 32'h1);
    bus.grantACK = 1'b0;
    step();
    chk("stv_hold", 32'(bus.CMDGrantVector), 32'h8);
    chk("stv_sg_pulse", 32'(bus.starveGrant), 32'h0);

    // Revoke: r2 blocked before ACK, back through IDLE
    reset_to(1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h0, 12'h0);
    step();
    chk("rvk_idle", 32'(bus.CMDGrantVector), 32'h0);
    set_in(1'b0, 4'b0100, 4'b0000, 4'b0000, {3'd0, 3'd1, 3'd0, 3'd0}, 12'h0);
    step();
    chk("rvk_latency", 32'(bus.CMDGrantVector), 32'h4);
    bus.fsmWaitVector = 4'b0100;
    step();
    chk("rvk_drop", 32'(bus.CMDGrantVector), 32'h0);
    chk("rvk_rt", 32'(bus.rankTransition), 32'h0);
    step();
    chk("rvk_stay", 32'(bus.CMDGrantVector), 32'h0);
    bus.fsmWaitVector = 4'b0000;
    step();
    chk("rvk_regrant", 32'(bus.CMDGrantVector), 32'h4);

    // ACK coincident with revoke condition counts as an issue: gap then r1
    reset_to(1'b0, 4'b0110, 4'b0000, 4'b0000, {3'd0, 3'd5, 3'd1, 3'd0}, 12'h0);
    step();
    chk("ackw_first", 32'(bus.CMDGrantVector), 32'h4);
    bus.fsmWaitVector = 4'b0100;
    bus.grantACK = 1'b1;
    step();
    chk("ackw_gap1", 32'(bus.CMDGrantVector), 32'h0);
    bus.grantACK = 1'b0;
    step();
    chk("ackw_gap2", 32'(bus.CMDGrantVector), 32'h0);
    step();
    chk("ackw_next", 32'(bus.CMDGrantVector), 32'h2);
    chk("ackw_rt", 32'(bus.rankTransition), 32'h1);

    // Mode switch during GRANT revokes; re-arbitration uses write counts
    reset_to(1'b0, 4'b1111, 4'b1111, 4'b0000, {3'd1, 3'd1, 3'd1, 3'd7}, {3'd7, 3'd0, 3'd0, 3'd0});
    step();
    chk("mode_rd", 32'(bus.CMDGrantVector), 32'h1);
    bus.writeMode = 1'b1;
    step();
    chk("mode_drop", 32'(bus.CMDGrantVector), 32'h0);
    step();
    chk("mode_wr", 32'(bus.CMDGrantVector), 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
